// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: sequencer state encoding, halt-cause codes and opcodes.
// The opcodes are also used by the instruction decoder.
package mu0_pkg;

    // One-hot state encoding. Bits [2:0] are the fetch/exec1/exec2 strobes.
    localparam logic [4:0] ST_FETCH  = 5'b00001;
    localparam logic [4:0] ST_EXEC1  = 5'b00010;
    localparam logic [4:0] ST_EXEC2  = 5'b00100;
    localparam logic [4:0] ST_HALTED = 5'b01000;
    localparam logic [4:0] ST_PAUSED = 5'b10000;

    typedef enum logic [1:0] {
        CAUSE_RESET = 2'b00,
        CAUSE_STP   = 2'b01,
        CAUSE_STOP  = 2'b10
    } halt_cause_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_STO = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JGE = 4'b0101;
    localparam logic [3:0] OP_JNE = 4'b0110;
    localparam logic [3:0] OP_STP = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_LSL = 4'b1001;
    localparam logic [3:0] OP_LSR = 4'b1010;

    function automatic logic state_is_active(input logic [4:0] st);
        return |st[2:0];
    endfunction

endpackage

// File: rtl/mu0_sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module mu0_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 control-timing generator: fetch/exec1/exec2 phase strobes, run/step/stop
// control with STP detection, and saturating cycle/instruction counters.
module mu0_sequencer
    import mu0_pkg::*;
#(
    parameter int         CNT_W  = 16,
    parameter logic [3:0] STP_OP = OP_STP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step,
    input  logic             stop_req,
    input  logic [3:0]       op,
    input  logic             extra,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic             halted,
    output logic             paused,
    output logic [1:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    logic [4:0]  state_q;
    logic [4:0]  state_d;
    halt_cause_e halt_cause_q;
    halt_cause_e halt_cause_d;
    logic        stop_pending_q;
    logic        stop_pending_d;
    logic        count_clr;
    logic        boundary;
    logic        is_stp;
    logic        cycle_en;
    logic        instr_en;

    assign is_stp = (op == STP_OP);

    always_comb begin
        state_d        = state_q;
        halt_cause_d   = halt_cause_q;
        stop_pending_d = stop_pending_q;
        count_clr      = 1'b0;
        boundary       = 1'b0;

        case (state_q)
            ST_HALTED: begin
                if (start) begin
                    state_d        = ST_FETCH;
                    stop_pending_d = 1'b0;
                    count_clr      = 1'b1;
                end
            end
            ST_FETCH: begin
                state_d = ST_EXEC1;
                if (stop_req) begin
                    stop_pending_d = 1'b1;
                end
            end
            ST_EXEC1: begin
                if (is_stp) begin
                    state_d        = ST_HALTED;
                    halt_cause_d   = CAUSE_STP;
                    stop_pending_d = 1'b0;
                end else if (extra) begin
                    state_d = ST_EXEC2;
                    if (stop_req) begin
                        stop_pending_d = 1'b1;
                    end
                end else begin
                    boundary = 1'b1;
                end
            end
            ST_EXEC2: begin
                boundary = 1'b1;
            end
            ST_PAUSED: begin
                if (stop_req) begin
                    state_d        = ST_HALTED;
                    halt_cause_d   = CAUSE_STOP;
                    stop_pending_d = 1'b0;
                end else if (step) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                // Any non-one-hot encoding recovers to a safe halt.
                state_d = ST_HALTED;
            end
        endcase

        // Instruction boundary: a pending or simultaneous stop beats step mode.
        if (boundary) begin
            if (stop_pending_q || stop_req) begin
                state_d        = ST_HALTED;
                halt_cause_d   = CAUSE_STOP;
                stop_pending_d = 1'b0;
            end else if (step_mode) begin
                state_d = ST_PAUSED;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_HALTED;
            halt_cause_q   <= CAUSE_RESET;
            stop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            halt_cause_q   <= halt_cause_d;
            stop_pending_q <= stop_pending_d;
        end
    end

    assign cycle_en = state_is_active(state_q);
    assign instr_en = ((state_q == ST_EXEC1) && (is_stp || !extra)) ||
                      (state_q == ST_EXEC2);

    mu0_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (count_clr),
        .en    (cycle_en),
        .count (cycle_count)
    );

    mu0_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (count_clr),
        .en    (instr_en),
        .count (instr_count)
    );

    assign fetch      = state_q[0];
    assign exec1      = state_q[1];
    assign exec2      = state_q[2];
    assign halted     = state_q[3];
    assign paused     = state_q[4];
    assign halt_cause = halt_cause_q;

endmodule
